// File: rtl/word_byte_serializer.sv
// Byte serializer for one packed 32-bit word (w, x, y, z) with an optional
// XOR checksum byte at the end. A word is captured on in_valid && in_ready and
// sent one byte per out_valid/out_ready handshake. A new word can be accepted
// in the same cycle as the final-byte handshake, so words go out back to back.
//
//   state | meaning
//   IDLE  | no word held, in_ready=1, out_valid=0
//   SEND  | captured word being sent, out_valid=1
module word_byte_serializer #(
    parameter int CHK_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] w,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] z,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    // Index of the final byte: z (3) without checksum, checksum (4) with it.
    localparam logic [2:0] LAST_IDX = (CHK_EN != 0) ? 3'd4 : 3'd3;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cap_w, cap_x, cap_y, cap_z, cap_chk;
    logic [7:0] cap_w_nx, cap_x_nx, cap_y_nx, cap_z_nx, cap_chk_nx;
    logic [2:0] idx, idx_nx, idx_inc;
    logic [7:0] out_data_nx, next_byte;
    logic       out_valid_nx, out_last_nx;
    logic       accept, hs;

    // The out_ready -> in_ready path is combinational on purpose: it lets a
    // new word be taken in the same cycle the final byte leaves.
    assign in_ready = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign busy     = (state == SEND);
    assign idx_inc  = idx + 3'd1;

    // Select the byte that follows the one currently presented.
    always_comb begin
        next_byte = cap_chk;
        case (idx_inc)
            3'd1:    next_byte = cap_x;
            3'd2:    next_byte = cap_y;
            3'd3:    next_byte = cap_z;
            default: next_byte = cap_chk;
        endcase
    end

    // Next-state, capture and output register logic.
    always_comb begin
        state_nx     = state;
        cap_w_nx     = cap_w;
        cap_x_nx     = cap_x;
        cap_y_nx     = cap_y;
        cap_z_nx     = cap_z;
        cap_chk_nx   = cap_chk;
        idx_nx       = idx;
        out_data_nx  = out_data;
        out_valid_nx = out_valid;
        out_last_nx  = out_last;

        if (accept) begin
            // Covers both IDLE accept and accept on the final-byte handshake.
            state_nx     = SEND;
            cap_w_nx     = w;
            cap_x_nx     = x;
            cap_y_nx     = y;
            cap_z_nx     = z;
            cap_chk_nx   = w ^ x ^ y ^ z;
            idx_nx       = 3'd0;
            out_data_nx  = w;
            out_valid_nx = 1'b1;
            out_last_nx  = 1'b0;
        end else if (hs) begin
            if (out_last) begin
                state_nx     = IDLE;
                out_valid_nx = 1'b0;
                out_last_nx  = 1'b0;
            end else begin
                idx_nx      = idx_inc;
                out_data_nx = next_byte;
                out_last_nx = (idx_inc == LAST_IDX);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_w     <= 8'h00;
            cap_x     <= 8'h00;
            cap_y     <= 8'h00;
            cap_z     <= 8'h00;
            cap_chk   <= 8'h00;
            idx       <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            cap_w     <= cap_w_nx;
            cap_x     <= cap_x_nx;
            cap_y     <= cap_y_nx;
            cap_z     <= cap_z_nx;
            cap_chk   <= cap_chk_nx;
            idx       <= idx_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench for word_byte_serializer. Expected {last, byte} pairs are
// queued when a word is handed to the DUT; monitors pop and compare on every
// output handshake. One instance with checksum, one without.
module tb_word_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] w, x, y, z;
    logic       in_valid, in_valid0;
    logic       in_ready, in_ready0;
    logic [7:0] out_data, out_data0;
    logic       out_valid, out_valid0;
    logic       out_ready, out_ready0;
    logic       out_last, out_last0;
    logic       busy, busy0;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] q1[$];
    logic [8:0] q0[$];

    always #5 clk = ~clk;

    word_byte_serializer #(.CHK_EN(1)) dut1 (
        .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    word_byte_serializer #(.CHK_EN(0)) dut0 (
        .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_last(out_last0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] a, b, c, d);
        q1.push_back({1'b0, a});
        q1.push_back({1'b0, b});
        q1.push_back({1'b0, c});
        q1.push_back({1'b0, d});
        q1.push_back({1'b1, a ^ b ^ c ^ d});
    endtask

    task automatic push0(input logic [7:0] a, b, c, d);
        q0.push_back({1'b0, a});
        q0.push_back({1'b0, b});
        q0.push_back({1'b0, c});
        q0.push_back({1'b1, d});
    endtask

    // Offer a word, wait (bounded) for in_ready, expect w one cycle later.
    task automatic send_word(input logic [7:0] a, b, c, d, input bit also0);
        bit ok = 0;
        w = a; x = b; y = c; z = d;
        in_valid = 1'b1;
        in_valid0 = also0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        push1(a, b, c, d);
        if (also0) push0(a, b, c, d);
        tick();
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_data", {24'd0, out_data}, {24'd0, a});
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (q1.size() == 0 && q0.size() == 0) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d/%0d bytes left, expected 0", q1.size(), q0.size());
        end
        tick();
        tick();
    endtask

    // Monitor for the checksum instance.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_byte1: got %h, expected no byte", out_data);
                end else begin
                    e = q1.pop_front();
                    check("byte_chk1", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
        end
    end

    // Monitor for the no-checksum instance.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_byte0: got %h, expected no byte", out_data0);
                end else begin
                    e = q0.pop_front();
                    check("byte_chk0", {23'd0, out_last0, out_data0}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        w = 8'h00; x = 8'h00; y = 8'h00; z = 8'h00;
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        out_ready0 = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Zero-heavy word: checksum equals z.
        send_word(8'h00, 8'h00, 8'h00, 8'h07, 1'b0);
        check("busy_send", {31'd0, busy}, 32'd1);
        drain();

        // Same word through both checksum settings.
        send_word(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
        drain();

        // Backpressure on byte 34 for three cycles.
        send_word(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        tick();
        check("bp_first", {24'd0, out_data}, 32'h34);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", {24'd0, out_data}, 32'h34);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_last", {31'd0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_resume", {24'd0, out_data}, 32'h56);
        drain();

        // Back-to-back words with in_valid held high.
        w = 8'h12; x = 8'h34; y = 8'h56; z = 8'h78;
        in_valid = 1'b1;
        check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
        push1(8'h12, 8'h34, 8'h56, 8'h78);
        tick();
        w = 8'hAA; x = 8'hBB; y = 8'hCC; z = 8'hDD;
        for (int k = 0; k < 5; k++) begin
            check("b2b_in_ready", {31'd0, in_ready}, {31'd0, (k == 4)});
            if (k == 4) push1(8'hAA, 8'hBB, 8'hCC, 8'hDD);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_no_gap_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_no_gap_data", {24'd0, out_data}, 32'hAA);
        drain();

        // Inputs change mid-word; captured bytes must go out.
        send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        w = 8'hFF; x = 8'hFF; y = 8'hFF; z = 8'hFF;
        drain();

        // Reset in the middle of a word.
        send_word(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_data == 8'h56) begin found = 1; break; end
            tick();
        end
        check("reach_56", {31'd0, found}, 32'd1);
        rst = 1'b1;
        q1.delete();
        tick();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_no_residual", {31'd0, out_valid}, 32'd0);
        send_word(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
        drain();

        check("q1_empty", q1.size(), 32'd0);
        check("q0_empty", q0.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
